// File: rtl/abba_gen.sv
// abba_gen: emits the symbol word a,b,b,a on a 2-bit bus, repeated on request with optional separators.
// Build option ABBA_GEN_ERR_INJECT_EN adds an inject input that corrupts the final word to a,b,a,a.
module abba_gen #(
    parameter int GAP   = 2,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
`ifdef ABBA_GEN_ERR_INJECT_EN
    input  logic             inject,
`endif
    input  logic             ready,
    output logic [1:2]       x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] SYM_A = 2'b00;
    localparam logic [1:0] SYM_B = 2'b01;
    localparam logic [1:0] SYM_D = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         x_q, x_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               corrupt_last;
    logic               last_word;

`ifdef ABBA_GEN_ERR_INJECT_EN
    logic               inj_q, inj_d;
    assign corrupt_last = inj_q;
`else
    assign corrupt_last = 1'b0;
`endif

    // Symbol at position idx of a word; a corrupted word swaps its third symbol from b to a.
    function automatic logic [1:0] word_sym(input logic [1:0] idx, input logic corrupt);
        logic [1:0] sym;
        case (idx)
            2'd0:    sym = SYM_A;
            2'd1:    sym = SYM_B;
            2'd2:    sym = corrupt ? SYM_A : SYM_B;
            default: sym = SYM_A;
        endcase
        return sym;
    endfunction

    assign accept    = valid_q & ready;
    assign last_word = (words_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        gap_d   = gap_q;
        x_d     = x_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ABBA_GEN_ERR_INJECT_EN
        inj_d   = inj_q;
`endif
        case (state_q)
            S_IDLE: begin
                x_d     = SYM_D;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    words_d = count;
                    idx_d   = 2'd0;
                    gap_d   = '0;
                    busy_d  = 1'b1;
`ifdef ABBA_GEN_ERR_INJECT_EN
                    inj_d   = inject;
`endif
                    if (count != '0) begin
                        state_d = S_SEND;
                        x_d     = SYM_A;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (accept) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        x_d   = word_sym(idx_q + 2'd1, corrupt_last && last_word);
                    end else begin
                        idx_d   = 2'd0;
                        words_d = words_q - CNT_W'(1);
                        if (last_word) begin
                            state_d = S_DONE;
                            x_d     = SYM_D;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                            x_d     = SYM_D;
                        end else begin
                            x_d = SYM_A;
                        end
                    end
                end
            end

            S_GAP: begin
                // Separators are counted only when the consumer takes them.
                if (accept) begin
                    if (gap_q == GAP_W'(GAP - 1)) begin
                        state_d = S_SEND;
                        idx_d   = 2'd0;
                        gap_d   = '0;
                        x_d     = SYM_A;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                x_d     = SYM_D;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                x_d     = SYM_D;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            words_q <= '0;
            gap_q   <= '0;
            x_q     <= SYM_D;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ABBA_GEN_ERR_INJECT_EN
            inj_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            gap_q   <= gap_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ABBA_GEN_ERR_INJECT_EN
            inj_q   <= inj_d;
`endif
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
